instr_fetch: RTL and testbench



---
 rtl/instr_fetch_if.sv | 25 ++
 rtl/instr_fetch.sv | 87 ++++++++
 tb/tb_instr_fetch.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Instruction memory bus for the LEGLite fetch unit.
// The fetch unit is the master: it raises imem_req with imem_addr and
// holds them until the memory answers with imem_ack and imem_data.
interface instr_fetch_if #(
    parameter int PC_WIDTH = 16
);
    logic                imem_req;
    logic [PC_WIDTH-1:0] imem_addr;
    logic                imem_ack;
    logic [15:0]         imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data
    );
endinterface

// File: rtl/instr_fetch.sv
// Multi-cycle instruction fetch/sequencer for the LEGLite CPU.
// Owns the PC, the instruction register and the retired-instruction count.
// Runs IDLE -> FETCH -> ISSUE, handshaking with instruction memory in FETCH
// and waiting for the datapath in ISSUE, where the next PC is chosen
// between sequential (pc + 2) and a taken CBZ (pc + sext(offset) << 1).
module instr_fetch #(
    parameter int                  PC_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 halt,
    instr_fetch_if.master        imem,
    output logic [15:0]          instr,
    output logic [2:0]           opcode,
    output logic                 instr_valid,
    input  logic                 exec_done,
    input  logic                 branch,
    input  logic                 zero,
    output logic [PC_WIDTH-1:0]  pc,
    output logic [PC_WIDTH-1:0]  icount
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                fetch_done;
    logic                retire;
    logic [PC_WIDTH-1:0] branch_offset;
    logic [PC_WIDTH-1:0] pc_next;

    // Strobes only count in the state that owns them; stray acks or
    // exec_done pulses elsewhere fall through without effect.
    assign fetch_done = (state == FETCH) && imem.imem_ack;
    assign retire     = (state == ISSUE) && exec_done;

    // CBZ offset is a signed 10-bit halfword count relative to the CBZ itself.
    assign branch_offset = {{(PC_WIDTH-11){instr[12]}}, instr[12:3], 1'b0};
    assign pc_next       = (branch && zero) ? (pc + branch_offset)
                                            : (pc + PC_WIDTH'(2));

    // Bus and issue outputs are pure decodes of the state register.
    assign imem.imem_req  = (state == FETCH);
    assign imem.imem_addr = pc;
    assign instr_valid    = (state == ISSUE);
    assign opcode         = instr[15:13];

    // Next-state decode; halt is only honoured when leaving IDLE or ISSUE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!halt)      state_next = FETCH;
            FETCH:   if (fetch_done) state_next = ISSUE;
            ISSUE:   if (retire)     state_next = halt ? IDLE : FETCH;
            default:                 state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Instruction register loads on the acknowledged fetch edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)        instr <= 16'h0000;
        else if (fetch_done) instr <= imem.imem_data;
    end

    // PC and retired count advance together when the datapath finishes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc     <= RESET_PC;
            icount <= '0;
        end else if (retire) begin
            pc     <= pc_next;
            icount <= icount + PC_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch.
// The main instance starts at PC 0000; a second instance with RESET_PC
// FFFE runs free with memory and datapath always ready to show PC wrap.
module tb_instr_fetch;

    logic        clock;
    logic        reset_n;
    logic        halt;
    logic        exec_done;
    logic        branch;
    logic        zero;
    logic [15:0] instr;
    logic [2:0]  opcode;
    logic        instr_valid;
    logic [15:0] pc;
    logic [15:0] icount;

    logic        halt2;
    logic        exec_done2;
    logic        branch2;
    logic        zero2;
    logic [15:0] instr2;
    logic [2:0]  opcode2;
    logic        instr_valid2;
    logic [15:0] pc2;
    logic [15:0] icount2;

    int          checks_total;
    int          checks_passed;
    logic [15:0] exp_icount;

    instr_fetch_if #(.PC_WIDTH(16)) imem ();
    instr_fetch_if #(.PC_WIDTH(16)) imem2 ();

    instr_fetch #(.PC_WIDTH(16), .RESET_PC(16'h0000)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .halt        (halt),
        .imem        (imem.master),
        .instr       (instr),
        .opcode      (opcode),
        .instr_valid (instr_valid),
        .exec_done   (exec_done),
        .branch      (branch),
        .zero        (zero),
        .pc          (pc),
        .icount      (icount)
    );

    instr_fetch #(.PC_WIDTH(16), .RESET_PC(16'hFFFE)) dut_wrap (
        .clock       (clock),
        .reset_n     (reset_n),
        .halt        (halt2),
        .imem        (imem2.master),
        .instr       (instr2),
        .opcode      (opcode2),
        .instr_valid (instr_valid2),
        .exec_done   (exec_done2),
        .branch      (branch2),
        .zero        (zero2),
        .pc          (pc2),
        .icount      (icount2)
    );

    // Free-running 10 ns clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks_total++;
        if (actual === expected) checks_passed++;
        else $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One full instruction starting in FETCH at cur_pc: memory acks after
    // ack_wait cycles, datapath finishes after exec_wait ISSUE cycles.
    task automatic applyStimulus(input logic [15:0] cur_pc, input logic [15:0] data,
                                 input int ack_wait, input int exec_wait,
                                 input bit br, input bit z, input bit halt_in_issue,
                                 input logic [15:0] exp_pc);
        checkOutput("fetch_addr", 32'(imem.imem_addr), 32'(cur_pc));
        for (int i = 0; i < ack_wait; i++) begin
            tick();
            checkOutput("req_held", 32'(imem.imem_req), 32'd1);
            checkOutput("addr_held", 32'(imem.imem_addr), 32'(cur_pc));
        end
        imem.imem_ack  = 1'b1;
        imem.imem_data = data;
        tick();
        imem.imem_ack  = 1'b0;
        imem.imem_data = 16'hDEAD;
        checkOutput("issue_valid", 32'(instr_valid), 32'd1);
        checkOutput("issue_req", 32'(imem.imem_req), 32'd0);
        checkOutput("issue_instr", 32'(instr), 32'(data));
        checkOutput("issue_opcode", 32'(opcode), 32'(data[15:13]));
        if (halt_in_issue) halt = 1'b1;
        for (int i = 0; i < exec_wait; i++) begin
            tick();
            checkOutput("issue_held", 32'(instr_valid), 32'd1);
            checkOutput("issue_pc_held", 32'(pc), 32'(cur_pc));
        end
        exec_done = 1'b1;
        branch    = br;
        zero      = z;
        tick();
        exec_done = 1'b0;
        branch    = 1'b0;
        zero      = 1'b0;
        exp_icount++;
        checkOutput("next_pc", 32'(pc), 32'(exp_pc));
        checkOutput("next_addr", 32'(imem.imem_addr), 32'(exp_pc));
        checkOutput("icount", 32'(icount), 32'(exp_icount));
        checkOutput("retired_valid", 32'(instr_valid), 32'd0);
        checkOutput("retired_req", 32'(imem.imem_req), halt ? 32'd0 : 32'd1);
    endtask

    // Wrap instance: memory and datapath always ready, sequential only.
    initial begin
        halt2           = 1'b0;
        exec_done2      = 1'b1;
        branch2         = 1'b0;
        zero2           = 1'b0;
        imem2.imem_ack  = 1'b1;
        imem2.imem_data = 16'h0000;
        @(posedge reset_n);
        @(posedge clock);
        #1;
        checkOutput("wrap_first_addr", 32'(imem2.imem_addr), 32'h0000FFFE);
        @(posedge clock);
        @(posedge clock);
        #1;
        checkOutput("wrap_pc", 32'(pc2), 32'h00000000);
        checkOutput("wrap_icount", 32'(icount2), 32'd1);
    end

    // Main directed sequence.
    initial begin
        checks_total   = 0;
        checks_passed  = 0;
        exp_icount     = 16'h0000;
        reset_n        = 1'b0;
        halt           = 1'b0;
        exec_done      = 1'b0;
        branch         = 1'b0;
        zero           = 1'b0;
        imem.imem_ack  = 1'b0;
        imem.imem_data = 16'h0000;

        #12;
        checkOutput("rst_pc", 32'(pc), 32'h0000);
        checkOutput("rst_icount", 32'(icount), 32'h0000);
        checkOutput("rst_instr", 32'(instr), 32'h0000);
        checkOutput("rst_opcode", 32'(opcode), 32'h0);
        checkOutput("rst_req", 32'(imem.imem_req), 32'd0);
        checkOutput("rst_valid", 32'(instr_valid), 32'd0);

        reset_n = 1'b1;
        tick();
        checkOutput("first_req", 32'(imem.imem_req), 32'd1);

        // Sequential run with slow memory and one-cycle execution delay.
        applyStimulus(16'h0000, 16'h1230, 2, 1, 1'b0, 1'b0, 1'b0, 16'h0002);
        applyStimulus(16'h0002, 16'h1231, 2, 1, 1'b0, 1'b0, 1'b0, 16'h0004);
        applyStimulus(16'h0004, 16'h1232, 2, 1, 1'b0, 1'b0, 1'b0, 16'h0006);

        // Back-to-back minimum-latency instructions up to 0010.
        for (int i = 0; i < 5; i++)
            applyStimulus(16'h0006 + 16'(2*i), 16'h0100, 0, 0, 1'b0, 1'b0, 1'b0,
                          16'h0008 + 16'(2*i));

        // CBZ offset -1: taken goes back one halfword, not taken falls through.
        applyStimulus(16'h0010, 16'hBFF8, 0, 0, 1'b1, 1'b1, 1'b0, 16'h000E);
        applyStimulus(16'h000E, 16'h2000, 0, 0, 1'b0, 1'b0, 1'b0, 16'h0010);
        applyStimulus(16'h0010, 16'hBFF8, 0, 1, 1'b1, 1'b0, 1'b0, 16'h0012);

        // Halt raised in ISSUE parks in IDLE after retiring.
        applyStimulus(16'h0012, 16'h4000, 0, 1, 1'b0, 1'b0, 1'b1, 16'h0014);
        tick();
        checkOutput("halt_idle_req", 32'(imem.imem_req), 32'd0);
        checkOutput("halt_idle_valid", 32'(instr_valid), 32'd0);
        halt = 1'b0;
        tick();
        checkOutput("unhalt_req", 32'(imem.imem_req), 32'd1);
        checkOutput("unhalt_addr", 32'(imem.imem_addr), 32'h0014);

        // Halt raised in FETCH still lets the request complete and issue.
        halt = 1'b1;
        applyStimulus(16'h0014, 16'h6000, 1, 0, 1'b0, 1'b0, 1'b0, 16'h0016);
        halt = 1'b0;
        tick();
        checkOutput("unhalt2_req", 32'(imem.imem_req), 32'd1);

        // CBZ offset +31 halfwords: 0016 + 003E.
        applyStimulus(16'h0016, 16'hA0F8, 0, 0, 1'b1, 1'b1, 1'b0, 16'h0054);

        // exec_done during FETCH is ignored.
        exec_done = 1'b1;
        branch    = 1'b1;
        zero      = 1'b1;
        tick();
        exec_done = 1'b0;
        branch    = 1'b0;
        zero      = 1'b0;
        checkOutput("stray_done_req", 32'(imem.imem_req), 32'd1);
        checkOutput("stray_done_pc", 32'(pc), 32'h0054);
        checkOutput("stray_done_icount", 32'(icount), 32'(exp_icount));

        // imem_ack during ISSUE is ignored.
        imem.imem_ack  = 1'b1;
        imem.imem_data = 16'hBFB0;
        tick();
        imem.imem_data = 16'hFFFF;
        tick();
        imem.imem_ack  = 1'b0;
        checkOutput("stray_ack_instr", 32'(instr), 32'hBFB0);
        checkOutput("stray_ack_valid", 32'(instr_valid), 32'd1);
        checkOutput("stray_ack_icount", 32'(icount), 32'(exp_icount));

        // Retire the CBZ (offset -10 halfwords): 0054 - 0014 = 0040.
        exec_done = 1'b1;
        branch    = 1'b1;
        zero      = 1'b1;
        tick();
        exec_done = 1'b0;
        branch    = 1'b0;
        zero      = 1'b0;
        exp_icount++;
        checkOutput("cbz_back_pc", 32'(pc), 32'h0040);
        checkOutput("cbz_back_icount", 32'(icount), 32'(exp_icount));

        // Asynchronous reset between edges while fetching at 0040.
        checkOutput("pre_rst_opcode", 32'(opcode), 32'h5);
        #3;
        reset_n = 1'b0;
        #1;
        exp_icount = 16'h0000;
        checkOutput("mid_rst_req", 32'(imem.imem_req), 32'd0);
        checkOutput("mid_rst_pc", 32'(pc), 32'h0000);
        checkOutput("mid_rst_icount", 32'(icount), 32'h0000);
        checkOutput("mid_rst_opcode", 32'(opcode), 32'h0);
        #2;
        reset_n = 1'b1;
        tick();
        checkOutput("post_rst_req", 32'(imem.imem_req), 32'd1);

        // CBZ at 0000 with offset -2 wraps to FFFC.
        applyStimulus(16'h0000, 16'hBFF0, 0, 0, 1'b1, 1'b1, 1'b0, 16'hFFFC);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
